bomb_manager: RTL and testbench

BOMB_MANAGER -- requirements
Module: bomb_manager

---
 rtl/bomb_manager.sv | 165 ++++++++++++++++
 tb/tb_bomb_manager.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bomb_manager.sv
// bomb_manager: fixed pool of bomb slots with placement arbitration, fuse timing and in-order explosion hand-off.
// Optional feature: define BOMB_REMOTE_DETONATE_EN to add detonate_req (rising edge sends every ARMED bomb to PENDING).
module bomb_manager #(
   parameter int MAX_BOMBS   = 6,
   parameter int FUSE_CYCLES = 400000000,
   parameter int TILE        = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       place_req,
   input  logic [9:0] b_x,
   input  logic [9:0] b_y,
   input  logic [9:0] v_x,
   input  logic [9:0] v_y,
   input  logic       explode_ready,
`ifdef BOMB_REMOTE_DETONATE_EN
   input  logic       detonate_req,
`endif
   output logic       explode_valid,
   output logic [9:0] explode_x,
   output logic [9:0] explode_y,
   output logic       place_ack,
   output logic       place_nack,
   output logic [2:0] active_count,
   output logic       full,
   output logic       bomb_on
);
   typedef enum logic [1:0] {S_IDLE, S_ARMED, S_PENDING} slot_st_e;

   localparam logic [31:0] FUSE_LAST = 32'(FUSE_CYCLES - 1);
   localparam logic [9:0]  HALF      = 10'(TILE / 2);
   localparam logic [9:0]  TMASK     = ~10'(TILE - 1);
   localparam logic [10:0] TSPAN     = 11'(TILE - 1);

   slot_st_e    st_q  [MAX_BOMBS];
   slot_st_e    st_d  [MAX_BOMBS];
   logic [9:0]  x_q   [MAX_BOMBS];
   logic [9:0]  x_d   [MAX_BOMBS];
   logic [9:0]  y_q   [MAX_BOMBS];
   logic [9:0]  y_d   [MAX_BOMBS];
   logic [31:0] tmr_q [MAX_BOMBS];
   logic [31:0] tmr_d [MAX_BOMBS];

   logic       place_prev_q, lock_q, ack_q, nack_q, full_q, bomb_on_q;
   logic [2:0] sel_q, cnt_q, cnt_d;
   logic       rise, det_rise, accept, dup, free_found, pend_found, retire, bomb_on_d;
   logic [2:0] free_idx, pend_idx, sel;
   logic [9:0] tile_x, tile_y;

`ifdef BOMB_REMOTE_DETONATE_EN
   logic det_prev_q;
   assign det_rise = detonate_req & ~det_prev_q;
`else
   assign det_rise = 1'b0;
`endif

   always_comb begin
      rise       = place_req & ~place_prev_q;
      tile_x     = (b_x + HALF) & TMASK;
      tile_y     = (b_y + HALF) & TMASK;
      free_found = 1'b0;
      free_idx   = '0;
      pend_found = 1'b0;
      pend_idx   = '0;
      dup        = 1'b0;
      bomb_on_d  = 1'b0;
      // Descending scan so the lowest index is the last one written.
      for (int i = MAX_BOMBS - 1; i >= 0; i--) begin
         if (st_q[i] == S_IDLE) begin
            free_found = 1'b1;
            free_idx   = 3'(i);
         end
         if (st_q[i] == S_PENDING) begin
            pend_found = 1'b1;
            pend_idx   = 3'(i);
         end
         if (st_q[i] != S_IDLE) begin
            if (x_q[i] == tile_x && y_q[i] == tile_y) dup = 1'b1;
            if (v_x >= x_q[i] && {1'b0, v_x} <= {1'b0, x_q[i]} + TSPAN &&
                v_y >= y_q[i] && {1'b0, v_y} <= {1'b0, y_q[i]} + TSPAN)
               bomb_on_d = 1'b1;
         end
      end
      // A presented-but-unaccepted slot stays presented even if a lower slot expires meanwhile.
      sel    = lock_q ? sel_q : pend_idx;
      retire = pend_found & explode_ready;
      accept = rise & free_found & ~dup;
      cnt_d  = '0;
      for (int i = 0; i < MAX_BOMBS; i++) begin
         st_d[i]  = st_q[i];
         x_d[i]   = x_q[i];
         y_d[i]   = y_q[i];
         tmr_d[i] = tmr_q[i];
         case (st_q[i])
            S_IDLE:
               if (accept && free_idx == 3'(i)) begin
                  st_d[i]  = S_ARMED;
                  x_d[i]   = tile_x;
                  y_d[i]   = tile_y;
                  tmr_d[i] = '0;
               end
            S_ARMED:
               if (det_rise || tmr_q[i] == FUSE_LAST) begin
                  st_d[i]  = S_PENDING;
                  tmr_d[i] = '0;
               end else begin
                  tmr_d[i] = tmr_q[i] + 32'd1;
               end
            S_PENDING:
               if (retire && sel == 3'(i)) st_d[i] = S_IDLE;
            default: st_d[i] = S_IDLE;
         endcase
         if (st_d[i] != S_IDLE) cnt_d = cnt_d + 3'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < MAX_BOMBS; i++) begin
            st_q[i]  <= S_IDLE;
            x_q[i]   <= '0;
            y_q[i]   <= '0;
            tmr_q[i] <= '0;
         end
         place_prev_q <= 1'b1;
         lock_q       <= 1'b0;
         sel_q        <= '0;
         ack_q        <= 1'b0;
         nack_q       <= 1'b0;
         cnt_q        <= '0;
         full_q       <= 1'b0;
         bomb_on_q    <= 1'b0;
`ifdef BOMB_REMOTE_DETONATE_EN
         det_prev_q   <= 1'b1;
`endif
      end else begin
         for (int i = 0; i < MAX_BOMBS; i++) begin
            st_q[i]  <= st_d[i];
            x_q[i]   <= x_d[i];
            y_q[i]   <= y_d[i];
            tmr_q[i] <= tmr_d[i];
         end
         place_prev_q <= place_req;
         lock_q       <= pend_found & ~explode_ready;
         sel_q        <= sel;
         ack_q        <= accept;
         nack_q       <= rise & ~accept;
         cnt_q        <= cnt_d;
         full_q       <= (cnt_d == 3'(MAX_BOMBS));
         bomb_on_q    <= bomb_on_d;
`ifdef BOMB_REMOTE_DETONATE_EN
         det_prev_q   <= detonate_req;
`endif
      end
   end

   assign explode_valid = pend_found;
   assign explode_x     = pend_found ? x_q[sel] : '0;
   assign explode_y     = pend_found ? y_q[sel] : '0;
   assign place_ack     = ack_q;
   assign place_nack    = nack_q;
   assign active_count  = cnt_q;
   assign full          = full_q;
   assign bomb_on       = bomb_on_q;
endmodule

// File: tb/tb_bomb_manager.sv
// Self-checking bench for bomb_manager: directed scenarios plus randomized traffic against a slot-pool model.
module tb_bomb_manager;
   localparam int NB = 6, FUSE = 20, TL = 16;

   logic       clk = 1'b0;
   logic       reset, place_req, explode_ready;
   logic [9:0] b_x, b_y, v_x, v_y;
   logic       explode_valid, place_ack, place_nack, full, bomb_on;
   logic [9:0] explode_x, explode_y;
   logic [2:0] active_count;
   int         n_chk = 0, n_pass = 0;

   bomb_manager #(.MAX_BOMBS(NB), .FUSE_CYCLES(FUSE), .TILE(TL)) dut (
      .clk(clk), .reset(reset), .place_req(place_req),
      .b_x(b_x), .b_y(b_y), .v_x(v_x), .v_y(v_y),
      .explode_ready(explode_ready),
`ifdef BOMB_REMOTE_DETONATE_EN
      .detonate_req(1'b0),
`endif
      .explode_valid(explode_valid), .explode_x(explode_x), .explode_y(explode_y),
      .place_ack(place_ack), .place_nack(place_nack),
      .active_count(active_count), .full(full), .bomb_on(bomb_on)
   );

   always #5 clk = ~clk;

   // Model: slot state 0 idle, 1 armed, 2 waiting to explode; m_left counts fuse cycles still to burn.
   int m_st [NB];
   int m_x [NB], m_y [NB], m_left [NB];
   int m_pres = -1, m_cnt = 0;
   bit m_prev = 1'b1, m_ack = 1'b0, m_nack = 1'b0, m_full = 1'b0, m_bon = 1'b0;

   function automatic int m_show();
      if (m_pres >= 0) return m_pres;
      for (int i = 0; i < NB; i++) if (m_st[i] == 2) return i;
      return -1;
   endfunction

   always @(posedge clk) begin : model
      int  p, fr, tx, ty, vx, vy;
      bit  rise, dup;
      if (reset) begin
         for (int i = 0; i < NB; i++) begin
            m_st[i] = 0; m_x[i] = 0; m_y[i] = 0; m_left[i] = 0;
         end
         m_prev = 1'b1; m_pres = -1; m_ack = 1'b0; m_nack = 1'b0;
         m_cnt = 0; m_full = 1'b0; m_bon = 1'b0;
      end else begin
         rise   = place_req && !m_prev;
         m_prev = place_req;
         tx = ((int'(b_x) + TL / 2) % 1024) / TL * TL;
         ty = ((int'(b_y) + TL / 2) % 1024) / TL * TL;
         vx = int'(v_x);
         vy = int'(v_y);
         p  = m_show();
         fr = -1; dup = 1'b0; m_bon = 1'b0;
         for (int i = 0; i < NB; i++) begin
            if (m_st[i] == 0) begin
               if (fr < 0) fr = i;
            end else begin
               if (m_x[i] == tx && m_y[i] == ty) dup = 1'b1;
               if (vx >= m_x[i] && vx < m_x[i] + TL && vy >= m_y[i] && vy < m_y[i] + TL) m_bon = 1'b1;
            end
         end
         for (int i = 0; i < NB; i++)
            if (m_st[i] == 1) begin
               m_left[i]--;
               if (m_left[i] == 0) m_st[i] = 2;
            end
         if (p >= 0 && explode_ready) begin
            m_st[p] = 0;
            m_pres  = -1;
         end else m_pres = p;
         m_ack  = rise && fr >= 0 && !dup;
         m_nack = rise && !m_ack;
         if (m_ack) begin
            m_st[fr] = 1; m_x[fr] = tx; m_y[fr] = ty; m_left[fr] = FUSE;
         end
         m_cnt = 0;
         for (int i = 0; i < NB; i++) if (m_st[i] != 0) m_cnt++;
         m_full = (m_cnt == NB);
      end
   end

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drain();
      explode_ready = 1'b1;
      for (int k = 0; k < 200 && active_count != 3'd0; k++) step();
      explode_ready = 1'b0;
   endtask

   task automatic test_reset();
      step(); step();
      n_chk++;
      if ({explode_valid, explode_x, explode_y, place_ack, place_nack, active_count, full, bomb_on} !== 28'd0)
         $display("FAIL reset_outputs: got valid=%b x=%0d y=%0d ack=%b nack=%b cnt=%0d full=%b on=%b want all 0",
                  explode_valid, explode_x, explode_y, place_ack, place_nack, active_count, full, bomb_on);
      else n_pass++;
      reset = 1'b0;
      repeat (3) begin
         step();
         n_chk++;
         if ({place_ack, place_nack, active_count} !== 5'd0)
            $display("FAIL held_through_reset: got ack=%b nack=%b cnt=%0d want 0 0 0", place_ack, place_nack, active_count);
         else n_pass++;
      end
   endtask

   task automatic test_basic();
      int n;
      place_req = 1'b0; b_x = 10'd37; b_y = 10'd22;
      step();
      place_req = 1'b1;
      step();
      n_chk++;
      if ({place_ack, active_count} !== {1'b1, 3'd1})
         $display("FAIL basic_ack: got ack=%b cnt=%0d want 1 1", place_ack, active_count);
      else n_pass++;
      place_req = 1'b0;
      n = 0;
      while (!explode_valid && n < 40) begin step(); n++; end
      n_chk++;
      if (n !== 20) $display("FAIL basic_fuse_latency: got %0d cycles want 20", n);
      else n_pass++;
      n_chk++;
      if ({explode_x, explode_y} !== {10'd32, 10'd16})
         $display("FAIL basic_tile: got (%0d,%0d) want (32,16)", explode_x, explode_y);
      else n_pass++;
      explode_ready = 1'b1;
      step();
      explode_ready = 1'b0;
      n_chk++;
      if ({explode_valid, explode_x, explode_y, active_count} !== 24'd0)
         $display("FAIL basic_retire: got valid=%b x=%0d y=%0d cnt=%0d want 0 0 0 0",
                  explode_valid, explode_x, explode_y, active_count);
      else n_pass++;
   endtask

   task automatic test_full();
      for (int k = 0; k < 7; k++) begin
         b_x = 10'(k * 64); b_y = 10'd100;
         place_req = 1'b1;
         step();
         n_chk++;
         if ({place_ack, place_nack} !== ((k < 6) ? 2'b10 : 2'b01))
            $display("FAIL full_press%0d: got ack=%b nack=%b want %s", k, place_ack, place_nack, (k < 6) ? "ack" : "nack");
         else n_pass++;
         place_req = 1'b0;
         step();
      end
      n_chk++;
      if ({full, active_count} !== {1'b1, 3'd6})
         $display("FAIL full_state: got full=%b cnt=%0d want 1 6", full, active_count);
      else n_pass++;
      drain();
      n_chk++;
      if ({full, active_count} !== 4'd0) $display("FAIL full_drain: got full=%b cnt=%0d want 0 0", full, active_count);
      else n_pass++;
   endtask

   task automatic test_dup();
      logic [9:0] xs [3];
      logic [1:0] exp_an [3];
      logic [2:0] exp_cnt [3];
      // 37 and 39 round to tile 32; 40 rounds to tile 48
      xs = '{10'd37, 10'd39, 10'd40};
      exp_an = '{2'b10, 2'b01, 2'b10};
      exp_cnt = '{3'd1, 3'd1, 3'd2};
      b_y = 10'd22;
      for (int k = 0; k < 3; k++) begin
         b_x = xs[k];
         place_req = 1'b1;
         step();
         n_chk++;
         if ({place_ack, place_nack, active_count} !== {exp_an[k], exp_cnt[k]})
            $display("FAIL dup_press%0d: got ack=%b nack=%b cnt=%0d want %b %0d",
                     k, place_ack, place_nack, active_count, exp_an[k], exp_cnt[k]);
         else n_pass++;
         place_req = 1'b0;
         step();
      end
      drain();
   endtask

   task automatic place_pair();
      explode_ready = 1'b0; b_y = 10'd22;
      b_x = 10'd37;  place_req = 1'b1; step(); place_req = 1'b0; step();
      b_x = 10'd100; place_req = 1'b1; step(); place_req = 1'b0;
      for (int n = 0; n < 60 && !explode_valid; n++) step();
   endtask

   task automatic test_hold();
      place_pair();
      n_chk++;
      if ({explode_valid, explode_x, explode_y} !== {1'b1, 10'd32, 10'd16})
         $display("FAIL hold_first: got valid=%b (%0d,%0d) want 1 (32,16)", explode_valid, explode_x, explode_y);
      else n_pass++;
      repeat (5) begin
         step();
         n_chk++;
         if ({explode_valid, explode_x, explode_y} !== {1'b1, 10'd32, 10'd16})
            $display("FAIL hold_stable: got valid=%b (%0d,%0d) want 1 (32,16)", explode_valid, explode_x, explode_y);
         else n_pass++;
      end
      explode_ready = 1'b1;
      step();
      n_chk++;
      if ({explode_valid, explode_x, explode_y, active_count} !== {1'b1, 10'd96, 10'd16, 3'd1})
         $display("FAIL hold_second: got valid=%b (%0d,%0d) cnt=%0d want 1 (96,16) 1",
                  explode_valid, explode_x, explode_y, active_count);
      else n_pass++;
      step();
      explode_ready = 1'b0;
      n_chk++;
      if ({explode_valid, explode_x, explode_y, active_count} !== 24'd0)
         $display("FAIL hold_done: got valid=%b (%0d,%0d) cnt=%0d want all 0", explode_valid, explode_x, explode_y, active_count);
      else n_pass++;
   endtask

   task automatic test_bomb_on();
      int vt [6][3];
      vt = '{'{47, 31, 1}, '{48, 31, 0}, '{32, 16, 1}, '{31, 16, 0}, '{47, 32, 0}, '{40, 20, 1}};
      b_x = 10'd37; b_y = 10'd22;
      place_req = 1'b1; step(); place_req = 1'b0;
      for (int k = 0; k < 6; k++) begin
         v_x = 10'(vt[k][0]); v_y = 10'(vt[k][1]);
         step();
         n_chk++;
         if (bomb_on !== 1'(vt[k][2]))
            $display("FAIL bomb_on_(%0d,%0d): got %b want %0d", vt[k][0], vt[k][1], bomb_on, vt[k][2]);
         else n_pass++;
      end
      drain();
   endtask

   task automatic test_reset_pending();
      place_pair();
      step(); step(); step();
      place_req = 1'b1; reset = 1'b1;
      step();
      n_chk++;
      if ({explode_valid, explode_x, explode_y, place_ack, place_nack, active_count, full, bomb_on} !== 28'd0)
         $display("FAIL reset_pending: got valid=%b x=%0d y=%0d ack=%b nack=%b cnt=%0d full=%b on=%b want all 0",
                  explode_valid, explode_x, explode_y, place_ack, place_nack, active_count, full, bomb_on);
      else n_pass++;
      reset = 1'b0;
      repeat (4) begin
         step();
         n_chk++;
         if ({explode_valid, place_ack, place_nack, active_count} !== 6'd0)
            $display("FAIL post_reset_quiet: got valid=%b ack=%b nack=%b cnt=%0d want 0",
                     explode_valid, place_ack, place_nack, active_count);
         else n_pass++;
      end
      place_req = 1'b0; step();
      place_req = 1'b1; step();
      n_chk++;
      if ({place_ack, active_count} !== {1'b1, 3'd1})
         $display("FAIL post_reset_replace: got ack=%b cnt=%0d want 1 1", place_ack, active_count);
      else n_pass++;
      place_req = 1'b0;
      drain();
   endtask

   task automatic test_random();
      int p;
      logic [27:0] got, want;
      for (int c = 0; c < 800; c++) begin
         place_req     = 1'($urandom_range(0, 1));
         explode_ready = ($urandom_range(0, 3) != 0);
         b_x = ($urandom_range(0, 7) == 0) ? 10'($urandom_range(1000, 1023)) : 10'($urandom_range(0, 80));
         b_y = 10'($urandom_range(0, 40));
         v_x = 10'($urandom_range(0, 120));
         v_y = 10'($urandom_range(0, 70));
         step();
         p    = m_show();
         want = {p >= 0, (p >= 0) ? 10'(m_x[p]) : 10'd0, (p >= 0) ? 10'(m_y[p]) : 10'd0,
                 m_ack, m_nack, 3'(m_cnt), m_full, m_bon};
         got  = {explode_valid, explode_x, explode_y, place_ack, place_nack, active_count, full, bomb_on};
         n_chk++;
         if (got !== want) $display("FAIL random_cycle%0d: got %h want %h", c, got, want);
         else n_pass++;
      end
   endtask

   initial begin
      reset = 1'b1; place_req = 1'b1; explode_ready = 1'b0;
      b_x = '0; b_y = '0; v_x = '0; v_y = '0;
      test_reset();
      test_basic();
      test_full();
      test_dup();
      test_hold();
      test_bomb_on();
      test_reset_pending();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
